// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter and its read-tag FIFO.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Owner id carried per outstanding read: 0 = video port, 1 = CPU port.
  typedef logic owner_t;

  // Gnt-to-data latency of SDRAM_ctrl (CL2 pipeline).
  localparam int TRL    = 4;
  localparam int AW_DEF = 22;
  localparam int DW_DEF = 16;

endpackage

// File: rtl/sdram_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the owner id of every read still in flight.
module sdram_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_push,
  input  owner_t i_din,
  input  logic   i_pop,
  output owner_t o_dout,
  output logic   o_full,
  output logic   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [DEPTH-1:0] r_mem;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_dout  = r_mem[r_rptr[PW-1:0]];

  // A push while full is accepted only when a pop frees the slot in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mem  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[PW-1:0]] <= i_din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of SDRAM_ctrl: video read port 0 (priority) and CPU port 1.
// Build option ARB_FAIRNESS_EN bounds consecutive grants to one owner while the other waits.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int TAG_DEPTH = 2 * TRL
`ifdef ARB_FAIRNESS_EN
  ,
  parameter int MAX_RUN   = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic          sd_rd_req,
  input  logic          sd_rd_gnt,
  output logic          sd_wr_req,
  input  logic          sd_wr_gnt,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_wdata,
  input  logic [DW-1:0] sd_rdata,
  input  logic          sd_rvalid,
  output logic          err_orphan
);

  // Handshake: a port holds req (and its address/data) until it sees gnt high in a cycle;
  // that cycle's rising edge is the transfer. Read data comes back as a one-cycle rvalid pulse.

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic          w_gnt;
  logic          w_force;
  logic          w_skip0;
  logic          w_skip1;
  logic          w_full;
  logic          w_empty;
  owner_t        w_tag_in;
  owner_t        w_tag_out;
  logic          w_ret;
  logic          r_p0_rvalid;
  logic          r_p1_rvalid;
  logic [DW-1:0] r_p0_rdata;
  logic [DW-1:0] r_p1_rdata;
  logic          r_err;

  assign w_gnt    = sd_rd_gnt | sd_wr_gnt;
  assign w_tag_in = (r_state == OWN1);
  assign w_ret    = sd_rvalid & ~w_empty;

`ifdef ARB_FAIRNESS_EN
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  logic [RUN_W-1:0] r_run;
  logic             r_skip0;
  logic             r_skip1;
  logic             w_other_req;

  assign w_other_req = (r_state == OWN0) ? p1_req :
                       (r_state == OWN1) ? p0_req : 1'b0;
  assign w_force     = w_other_req & w_gnt & (r_run == RUN_W'(MAX_RUN - 1));
  assign w_skip0     = r_skip0;
  assign w_skip1     = r_skip1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run   <= '0;
      r_skip0 <= 1'b0;
      r_skip1 <= 1'b0;
    end else begin
      // The released owner is ignored for exactly the IDLE cycle that follows a forced release.
      r_skip0 <= (r_state == OWN0) & w_force;
      r_skip1 <= (r_state == OWN1) & w_force;
      if (w_next == IDLE) begin
        r_run <= '0;
      end else if (w_other_req & w_gnt) begin
        r_run <= r_run + 1'b1;
      end
    end
  end
`else
  assign w_force = 1'b0;
  assign w_skip0 = 1'b0;
  assign w_skip1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Owner passes straight through; release always goes via IDLE so the controller can precharge.
  always_comb begin
    w_next    = r_state;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    sd_rd_req = 1'b0;
    sd_wr_req = 1'b0;
    sd_addr   = '0;
    sd_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        if (p0_req & ~w_skip0) begin
          w_next = OWN0;
        end else if (p1_req & ~w_skip1) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        sd_rd_req = p0_req & ~w_full;
        sd_addr   = p0_addr;
        p0_gnt    = w_gnt;
        if (!p0_req || w_force) begin
          w_next = IDLE;
        end
      end
      OWN1: begin
        sd_rd_req = p1_req & ~p1_we & ~w_full;
        sd_wr_req = p1_req & p1_we;
        sd_addr   = p1_addr;
        sd_wdata  = p1_wdata;
        p1_gnt    = w_gnt;
        if (!p1_req || w_force) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  sdram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (sd_rd_gnt),
    .i_din   (w_tag_in),
    .i_pop   (sd_rvalid),
    .o_dout  (w_tag_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_p0_rvalid <= w_ret & ~w_tag_out;
      r_p1_rvalid <= w_ret & w_tag_out;
      if (w_ret & ~w_tag_out) begin
        r_p0_rdata <= sd_rdata;
      end
      if (w_ret & w_tag_out) begin
        r_p1_rdata <= sd_rdata;
      end
      // Data with no owner on record (e.g. in flight across a reset) is dropped.
      if (sd_rvalid & w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign p0_rvalid  = r_p0_rvalid;
  assign p1_rvalid  = r_p1_rvalid;
  assign p0_rdata   = r_p0_rdata;
  assign p1_rdata   = r_p1_rdata;
  assign err_orphan = r_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: SDRAM_ctrl model, port drivers, read-return scoreboard.
module tb_sdram_port_arbiter;

  localparam int AW        = 22;
  localparam int DW        = 16;
  localparam int TAG_DEPTH = 8;
  // Scoreboard entry: {check_cycle, port, data, due_cycle}
  localparam int EW        = 2 + DW + 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          sd_rd_req, sd_wr_req, sd_rd_gnt, sd_wr_gnt;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic [DW-1:0] sd_rdata  = '0;
  logic          sd_rvalid = 1'b0;
  logic          err_orphan;

  int            cyc   = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];
  int            p0_gc[16];
  int            p0_gcount;
  int            p1_gc;

  // SDRAM_ctrl model: one idle (activate) cycle before grants, data TRL cycles after a read gnt.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  logic          m_act = 1'b0;
  logic          stall = 1'b0;

`ifdef ARB_FAIRNESS_EN
  sdram_port_arbiter #(.AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH), .MAX_RUN(4)) dut (
`else
  sdram_port_arbiter #(.AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
`endif
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .sd_rd_req(sd_rd_req), .sd_rd_gnt(sd_rd_gnt), .sd_wr_req(sd_wr_req), .sd_wr_gnt(sd_wr_gnt),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
    .err_orphan(err_orphan)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sd_rd_gnt = sd_rd_req & m_act;
  assign sd_wr_gnt = sd_wr_req & m_act & ~sd_rd_req;

  always @(posedge clk) begin
    rd_t e;
    m_act <= sd_rd_req | sd_wr_req;
    if (sd_wr_gnt) mem[sd_addr] = sd_wdata;
    if (sd_rd_gnt) begin
      e.due  = cyc + 4;
      e.data = mem.exists(sd_addr) ? mem[sd_addr] : 16'h0000;
      rq.push_back(e);
    end
    sd_rvalid <= 1'b0;
    if (!stall && rq.size() > 0 && rq[0].due <= cyc + 1) begin
      sd_rvalid <= 1'b1;
      sd_rdata  <= rq[0].data;
      void'(rq.pop_front());
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (p0_rvalid || p1_rvalid) begin
      if (p0_rvalid && p1_rvalid) check("rvalid_both", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {p1_rvalid, p0_rvalid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_port", p1_rvalid, e[EW-2]);
        check("rdata", p1_rvalid ? p1_rdata : p0_rdata, e[DW+31:32]);
        if (e[EW-1]) check("rvalid_cycle", cyc, e[31:0]);
      end
    end
  end

  // Port 0 driver: n reads from base, addr held until each gnt
  task automatic p0_stream(input logic [AW-1:0] base, input int n,
                           input logic [DW-1:0] dbase, input bit chk_t);
    int t = 0;
    p0_gcount = 0;
    @(posedge clk); #1;
    p0_req  = 1'b1;
    p0_addr = base;
    for (int i = 0; i < n;) begin
      @(negedge clk);
      if (p0_gnt) begin
        p0_gc[i] = cyc;
        exp_q.push_back({chk_t, 1'b0, dbase + DW'(i), 32'(cyc + 5)});
        i++;
        p0_gcount = i;
        t = 0;
        @(posedge clk); #1;
        if (i < n) p0_addr = base + AW'(i);
        else p0_req = 1'b0;
      end else if (++t > 200) begin
        fail_timeout("p0_gnt");
        p0_req = 1'b0;
        break;
      end
    end
  endtask

  // Port 1 driver: one access
  task automatic p1_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_data);
    int t = 0;
    @(posedge clk); #1;
    p1_req   = 1'b1;
    p1_we    = we;
    p1_addr  = addr;
    p1_wdata = wdata;
    while (1) begin
      @(negedge clk);
      if (p1_gnt) begin
        p1_gc = cyc;
        if (!we) exp_q.push_back({1'b1, 1'b1, exp_data, 32'(cyc + 5)});
        @(posedge clk); #1;
        p1_req = 1'b0;
        p1_we  = 1'b0;
        break;
      end else if (++t > 200) begin
        fail_timeout("p1_gnt");
        p1_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic stall_watch();
    int t = 0;
    while (p0_gcount < 8 && t < 300) begin @(negedge clk); #2; t++; end
    if (p0_gcount < 8) fail_timeout("stall_fill");
    repeat (4) begin
      @(negedge clk); #2;
      check("full_masks_rd_req", sd_rd_req, 0);
    end
    stall = 1'b0;
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!sd_rvalid && t < 50);
    check("rd_req_at_first_rvalid", sd_rd_req, 0);
    @(negedge clk); #2;
    check("rd_req_resumes", sd_rd_req, 1);
  endtask

  task automatic drain(input string name);
    repeat (14) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, t;
    reset = 1'b1; p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_sd_req", {sd_rd_req, sd_wr_req}, 0);
    check("rst_sd_addr", sd_addr, 0);
    check("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
    check("rst_err_orphan", err_orphan, 0);
    @(posedge clk); #1; reset = 1'b0;

    // CPU write then read-back
    p1_access(1'b1, 22'h000105, 16'hBEEF, 16'h0000);
    p1_access(1'b0, 22'h000105, 16'h0000, 16'hBEEF);
    drain("drain_cpu");

    // Video stream of 8 reads
    for (int i = 0; i < 8; i++) mem[22'h100200 + i] = 16'h5A00 + 16'(i);
    p0_stream(22'h100200, 8, 16'h5A00, 1'b1);
    for (int i = 1; i < 8; i++) check("p0_consecutive_gnt", p0_gc[i], p0_gc[0] + i);
    drain("drain_stream");

    // Both request from IDLE: port 0 first, port 1 after release + IDLE
    mem[22'h100300] = 16'h1110; mem[22'h100301] = 16'h1111; mem[22'h000200] = 16'h3333;
    fork
      p0_stream(22'h100300, 2, 16'h1110, 1'b1);
      p1_access(1'b0, 22'h000200, 16'h0000, 16'h3333);
    join
    check("p0_wins_idle", p0_gc[0] < p1_gc, 1);
    check("p1_gnt_after_idle", p1_gc, p0_gc[1] + 4);
    drain("drain_prio");

    // Long video run with CPU waiting
    for (int i = 0; i < 8; i++) mem[22'h100400 + i] = 16'h4400 + 16'(i);
    mem[22'h000300] = 16'h7777;
    fork
      p0_stream(22'h100400, 8, 16'h4400, 1'b1);
      p1_access(1'b0, 22'h000300, 16'h0000, 16'h7777);
    join
`ifdef ARB_FAIRNESS_EN
    check("fair_p1_gnt", p1_gc, p0_gc[3] + 3);
    check("fair_p0_resume", p0_gc[4], p0_gc[3] + 7);
`else
    check("strict_p1_gnt", p1_gc, p0_gc[7] + 4);
`endif
    drain("drain_fair");

    // Tag FIFO full: stalled returns
    for (int i = 0; i < 9; i++) mem[22'h100500 + i] = 16'h5500 + 16'(i);
    stall = 1'b1;
    fork
      p0_stream(22'h100500, 9, 16'h5500, 1'b0);
      stall_watch();
    join
    drain("drain_full");
    check("no_orphan_yet", err_orphan, 0);

    // Reset two cycles after a CPU read gnt, request still pending
    mem[22'h000400] = 16'h9999; mem[22'h000401] = 16'h9998;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 22'h000400;
    g = -1; t = 0;
    while (g < 0 && t < 50) begin @(negedge clk); if (p1_gnt) g = cyc; t++; end
    if (g < 0) fail_timeout("rst_p1_gnt");
    @(posedge clk); #1; p1_addr = 22'h000401;
    @(posedge clk); #1; reset = 1'b1; #1;
    check("midrst_p1_gnt", p1_gnt, 0);
    check("midrst_sd_rd_req", sd_rd_req, 0);
    check("midrst_sd_addr", sd_addr, 0);
    check("midrst_rvalid", {p1_rvalid, p0_rvalid}, 0);
    @(posedge clk); #1; reset = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    check("orphan_before_return", err_orphan, 0);
    repeat (3) @(negedge clk);
    check("orphan_set", err_orphan, 1);
    repeat (5) @(negedge clk);
    check("orphan_sticky", err_orphan, 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
